// File: rtl/scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_pkg
// Brief    : Shared types, segment patterns and BCD decode for the scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
package scoreboard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_HOLD     = 2'd1,
    ST_REPEAT   = 2'd2,
    ST_WAIT_REL = 2'd3
  } ctrl_state_t;

  // Segment order a..g from MSB to LSB, active-high.
  localparam logic [6:0] c_seg_0     = 7'b1111110;
  localparam logic [6:0] c_seg_1     = 7'b0110000;
  localparam logic [6:0] c_seg_2     = 7'b1101101;
  localparam logic [6:0] c_seg_3     = 7'b1111001;
  localparam logic [6:0] c_seg_4     = 7'b0110011;
  localparam logic [6:0] c_seg_5     = 7'b1011011;
  localparam logic [6:0] c_seg_6     = 7'b1011111;
  localparam logic [6:0] c_seg_7     = 7'b1110000;
  localparam logic [6:0] c_seg_8     = 7'b1111111;
  localparam logic [6:0] c_seg_9     = 7'b1111011;
  localparam logic [6:0] c_seg_blank = 7'b0000000;

  function automatic logic [6:0] bcd_to_seg7(input logic [3:0] i_digit);
    logic [6:0] w_seg;
    case (i_digit)
      4'd0:    w_seg = c_seg_0;
      4'd1:    w_seg = c_seg_1;
      4'd2:    w_seg = c_seg_2;
      4'd3:    w_seg = c_seg_3;
      4'd4:    w_seg = c_seg_4;
      4'd5:    w_seg = c_seg_5;
      4'd6:    w_seg = c_seg_6;
      4'd7:    w_seg = c_seg_7;
      4'd8:    w_seg = c_seg_8;
      4'd9:    w_seg = c_seg_9;
      default: w_seg = c_seg_blank;
    endcase
    return w_seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_ctrl
// Brief    : One-action-per-press button controller with optional auto-repeat.
// Revision : 1.0 - initial release
// ============================================================================
module scoreboard_ctrl
  import scoreboard_pkg::*;
#(
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_erase,
  output logic o_inc_pulse,
  output logic o_dec_pulse,
  output logic o_erase_pulse
);

  localparam int c_timer_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int c_timer_w   = (c_timer_max > 2) ? $clog2(c_timer_max) : 1;

  localparam logic [c_timer_w-1:0] c_delay_last  =
    c_timer_w'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [c_timer_w-1:0] c_period_last =
    c_timer_w'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);

  ctrl_state_t          r_state;
  logic [c_timer_w-1:0] r_timer;
  logic                 r_dir_inc;
  logic                 r_inc_pulse;
  logic                 r_dec_pulse;
  logic                 r_erase_pulse;

  logic                 w_latched;
  logic                 w_other;
  logic [c_timer_w-1:0] w_limit;

  assign w_latched = r_dir_inc ? i_inc : i_dec;
  assign w_other   = r_dir_inc ? i_dec : i_inc;
  assign w_limit   = (r_state == ST_HOLD) ? c_delay_last : c_period_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_dir_inc     <= 1'b0;
      r_inc_pulse   <= 1'b0;
      r_dec_pulse   <= 1'b0;
      r_erase_pulse <= 1'b0;
    end else begin
      r_inc_pulse   <= 1'b0;
      r_dec_pulse   <= 1'b0;
      r_erase_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_erase) begin
            r_erase_pulse <= 1'b1;
            r_state       <= ST_WAIT_REL;
          end else if (i_inc ^ i_dec) begin
            r_inc_pulse <= i_inc;
            r_dec_pulse <= i_dec;
            r_dir_inc   <= i_inc;
            r_timer     <= '0;
            r_state     <= (REPEAT_DELAY == 0) ? ST_WAIT_REL : ST_HOLD;
          end else if (i_inc && i_dec) begin
            r_state <= ST_WAIT_REL;
          end
        end
        ST_HOLD, ST_REPEAT: begin
          // Erase wins over everything so a clear is never lost mid-hold.
          if (i_erase) begin
            r_erase_pulse <= 1'b1;
            r_state       <= ST_WAIT_REL;
          end else if (!w_latched) begin
            r_state <= ST_IDLE;
          end else if (w_other) begin
            r_state <= ST_WAIT_REL;
          end else if (r_timer == w_limit) begin
            r_inc_pulse <= r_dir_inc;
            r_dec_pulse <= !r_dir_inc;
            r_timer     <= '0;
            r_state     <= ST_REPEAT;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        ST_WAIT_REL: begin
          if (!(i_inc || i_dec || i_erase)) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_inc_pulse   = r_inc_pulse;
  assign o_dec_pulse   = r_dec_pulse;
  assign o_erase_pulse = r_erase_pulse;

endmodule
`default_nettype wire

// File: rtl/scoreboard_multi.sv
`default_nettype none
// ============================================================================
// Module   : scoreboard_multi
// Brief    : N-digit BCD scoreboard with wrap/saturate and per-digit 7-seg out.
// Revision : 1.0 - initial release
// ============================================================================
module scoreboard_multi
  import scoreboard_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int WRAP          = 0,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    inc_i,
  input  logic                    dec_i,
  input  logic                    erase_i,
  output logic [4*NUM_DIGITS-1:0] bcd_o,
  output logic [7*NUM_DIGITS-1:0] seg7_o,
  output logic                    at_max_o,
  output logic                    at_min_o
);

  localparam bit c_wrap = (WRAP != 0);

  logic                  w_inc_pulse;
  logic                  w_dec_pulse;
  logic                  w_erase_pulse;

  logic [3:0]            r_digit     [NUM_DIGITS];
  logic [3:0]            w_inc_digit [NUM_DIGITS];
  logic [3:0]            w_dec_digit [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] w_carry;
  logic [NUM_DIGITS-1:0] w_borrow;
  logic [NUM_DIGITS-1:0] w_is9;
  logic [NUM_DIGITS-1:0] w_is0;
  logic                  w_at_max;
  logic                  w_at_min;
  logic                  w_do_inc;
  logic                  w_do_dec;

  scoreboard_ctrl #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_ctrl (
    .clk           (clk),
    .rst           (rst),
    .i_inc         (inc_i),
    .i_dec         (dec_i),
    .i_erase       (erase_i),
    .o_inc_pulse   (w_inc_pulse),
    .o_dec_pulse   (w_dec_pulse),
    .o_erase_pulse (w_erase_pulse)
  );

  assign w_carry[0]  = 1'b1;
  assign w_borrow[0] = 1'b1;

  // Ripple chains: wrapping past max or below zero falls out of the chain naturally.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    assign w_is9[k] = (r_digit[k] == 4'd9);
    assign w_is0[k] = (r_digit[k] == 4'd0);

    assign w_inc_digit[k] = !w_carry[k]  ? r_digit[k] :
                            w_is9[k]     ? 4'd0 : r_digit[k] + 4'd1;
    assign w_dec_digit[k] = !w_borrow[k] ? r_digit[k] :
                            w_is0[k]     ? 4'd9 : r_digit[k] - 4'd1;

    if (k < NUM_DIGITS - 1) begin : g_chain
      assign w_carry[k+1]  = w_carry[k]  & w_is9[k];
      assign w_borrow[k+1] = w_borrow[k] & w_is0[k];
    end

    assign bcd_o[4*k +: 4]  = r_digit[k];
    assign seg7_o[7*k +: 7] = bcd_to_seg7(r_digit[k]);
  end

  assign w_at_max = &w_is9;
  assign w_at_min = &w_is0;
  assign w_do_inc = w_inc_pulse && (c_wrap || !w_at_max);
  assign w_do_dec = w_dec_pulse && (c_wrap || !w_at_min);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 4'd0;
    end else if (w_erase_pulse) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= 4'd0;
    end else if (w_do_inc) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= w_inc_digit[i];
    end else if (w_do_dec) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_digit[i] <= w_dec_digit[i];
    end
  end

  assign at_max_o = w_at_max;
  assign at_min_o = w_at_min;

endmodule
`default_nettype wire
